// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared phase encoding and opcode constants for the fetch/decode pipeline
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [1:0] OP_ALU   = 2'b11;
  localparam logic [3:0] FUNC_HLT = 4'b1111;

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } phase_e;

  // HLT is an ALU-class opcode with the all-ones function field
  function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
    return (word[15:14] == OP_ALU) && (word[7:4] == FUNC_HLT);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - wait-cycle counter for an outstanding instruction fetch
module fetch_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Terminal count is asserted while the counter sits at TIMEOUT
  assign tc = (cnt_q == TC_VAL);

  // Clear wins over enable; the counter saturates at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable && !tc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// rtl/instruction_fetch_sequencer.sv - PC, instruction register and five-phase sequencer
module instruction_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [INSTR_W-1:0] op,
  output logic [ADDR_W-1:0]  pc,
  output logic               p1,
  output logic               p2,
  output logic               p3,
  output logic               p4,
  output logic               p5,
  output logic               halted,
  output logic               fault
);

  logic [1:0]         rst_sync_q;
  logic               rst_int_n;

  phase_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] op_q, op_d;
  logic               req_q, req_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  logic               tmo_clear;
  logic               tmo_en;
  logic               tmo_tc;

  // Reset asserts immediately, releases two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Counter runs only while a fetch is waiting; it restarts on ack or on leaving FETCH
  assign tmo_en    = (state_q == ST_FETCH);
  assign tmo_clear = (state_q != ST_FETCH) || imem_ack || tmo_tc;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .tc     (tmo_tc)
  );

  // Next-state logic for the phase sequencer, PC, IR and status flags
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    op_d     = op_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    case (state_q)
      ST_STOP: begin
        if (start) begin
          state_d  = ST_FETCH;
          pc_d     = RESET_PC;
          fault_d  = 1'b0;
          halted_d = 1'b0;
        end
      end
      ST_FETCH: begin
        // An ack on the terminal-count cycle still completes the fetch
        if (imem_ack) begin
          op_d    = imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_tc) begin
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = ST_STOP;
        end
      end
      ST_DECODE: begin
        if (is_hlt(op_q)) begin
          halted_d = 1'b1;
          state_d  = ST_STOP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_MEM;
      ST_MEM:  state_d = ST_WB;
      ST_WB: begin
        if (br_taken) begin
          pc_d = br_target;
        end
        state_d = ST_FETCH;
      end
      default: state_d = ST_STOP;
    endcase
    // Request is registered so it rises with FETCH and falls the cycle after ack
    req_d = (state_d == ST_FETCH);
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= ST_STOP;
      pc_q     <= RESET_PC;
      op_q     <= '0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      req_q    <= req_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign op        = op_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

  assign p1 = (state_q == ST_FETCH);
  assign p2 = (state_q == ST_DECODE);
  assign p3 = (state_q == ST_EXEC);
  assign p4 = (state_q == ST_MEM);
  assign p5 = (state_q == ST_WB);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb/tb_instruction_fetch_sequencer.sv - directed table-driven bench for instruction_fetch_sequencer
module tb_instruction_fetch_sequencer;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic [15:0] rdata;
    int          wait_cyc;
    int          br_phase;    // 0 none, 3 pulse in EXEC, 5 pulse in WB
    logic [15:0] br_target;
    logic [15:0] addr;
    logic [15:0] next_addr;
    bit          halt;
    bit          start_with_ack;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] op;
  logic [15:0] pc;
  logic        p1, p2, p3, p4, p5;
  logic        halted;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[6];
  vec_t hv;

  instruction_fetch_sequencer #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .op         (op),
    .pc         (pc),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .p4         (p4),
    .p5         (p5),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] phases();
    return {p1, p2, p3, p4, p5};
  endfunction

  // Runs one instruction starting in FETCH, ends in FETCH of the next one (or in STOP on HLT)
  task automatic run_instr(input vec_t v);
    for (int w = 0; w < v.wait_cyc; w++) begin
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", 32'(imem_addr), 32'(v.addr));
      check("wait_phase", 32'(phases()), 32'b10000);
      check("wait_fault", 32'(fault), 32'd0);
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    start      = v.start_with_ack;
    check("ack_req", 32'(imem_req), 32'd1);
    check("ack_addr", 32'(imem_addr), 32'(v.addr));
    step();
    imem_ack   = 1'b0;
    start      = 1'b0;
    imem_rdata = 16'hDEAD;
    check("dec_phase", 32'(phases()), 32'b01000);
    check("dec_op", 32'(op), 32'(v.rdata));
    check("dec_pc", 32'(pc), 32'(v.addr + 16'd1));
    check("dec_req", 32'(imem_req), 32'd0);
    step();
    if (v.halt) begin
      check("hlt_phase", 32'(phases()), 32'b00000);
      check("hlt_halted", 32'(halted), 32'd1);
      check("hlt_req", 32'(imem_req), 32'd0);
      step();
      step();
      check("hlt_req_hold", 32'(imem_req), 32'd0);
      check("hlt_phase_hold", 32'(phases()), 32'b00000);
      return;
    end
    check("exec_phase", 32'(phases()), 32'b00100);
    check("exec_op", 32'(op), 32'(v.rdata));
    if (v.br_phase == 3) begin
      br_taken  = 1'b1;
      br_target = v.br_target;
    end
    step();
    br_taken = 1'b0;
    check("mem_phase", 32'(phases()), 32'b00010);
    step();
    check("wb_phase", 32'(phases()), 32'b00001);
    check("wb_op", 32'(op), 32'(v.rdata));
    check("wb_pc", 32'(pc), 32'(v.addr + 16'd1));
    if (v.br_phase == 5) begin
      br_taken  = 1'b1;
      br_target = v.br_target;
    end
    step();
    br_taken = 1'b0;
    check("nxt_phase", 32'(phases()), 32'b10000);
    check("nxt_req", 32'(imem_req), 32'd1);
    check("nxt_addr", 32'(imem_addr), 32'(v.next_addr));
  endtask

  initial begin
    vecs[0] = '{16'hC0C0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 3, 0, 16'h0000, 16'h0001, 16'h0002, 1'b0, 1'b1};
    vecs[2] = '{16'h5678, 1, 5, 16'h0040, 16'h0002, 16'h0040, 1'b0, 1'b0};
    vecs[3] = '{16'h80F0, 0, 3, 16'h0099, 16'h0040, 16'h0041, 1'b0, 1'b0};
    vecs[4] = '{16'h3FF0, 2, 0, 16'h0000, 16'h0041, 16'h0042, 1'b0, 1'b0};
    vecs[5] = '{16'hC0F0, 0, 0, 16'h0000, 16'h0042, 16'h0043, 1'b1, 1'b0};

    rst_n      = 1'b0;
    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    br_taken   = 1'b0;
    br_target  = 16'h0000;
    #12;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_phase", 32'(phases()), 32'b00000);
    check("rst_op", 32'(op), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    rst_n = 1'b1;
    step(); step(); step();
    check("idle_phase", 32'(phases()), 32'b00000);
    check("idle_req", 32'(imem_req), 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_p1", 32'(phases()), 32'b10000);
    check("start_req", 32'(imem_req), 32'd1);
    check("start_addr", 32'(imem_addr), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_instr(vecs[i]);
    end
    check("hlt_pc", 32'(pc), 32'h0043);

    // Restart after HLT, fetch one word, then let the next fetch time out
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_addr", 32'(imem_addr), 32'd0);
    check("restart_halted", 32'(halted), 32'd0);
    check("restart_req", 32'(imem_req), 32'd1);
    hv = '{16'h0001, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    run_instr(hv);

    for (int i = 0; i <= TIMEOUT; i++) begin
      check("tmo_req", 32'(imem_req), 32'd1);
      check("tmo_nofault", 32'(fault), 32'd0);
      step();
    end
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_halted", 32'(halted), 32'd1);
    check("tmo_req_low", 32'(imem_req), 32'd0);
    check("tmo_phase", 32'(phases()), 32'b00000);
    check("tmo_op", 32'(op), 32'h0001);
    step();
    check("tmo_sticky", 32'(fault), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_halted", 32'(halted), 32'd0);
    check("clr_addr", 32'(imem_addr), 32'd0);
    check("clr_req", 32'(imem_req), 32'd1);

    // Asynchronous reset in the middle of an outstanding fetch
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_phase", 32'(phases()), 32'b00000);
    check("arst_op", 32'(op), 32'd0);
    check("arst_pc", 32'(pc), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    check("late_ack_op", 32'(op), 32'd0);
    check("late_ack_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    step(); step(); step();
    check("post_rst_phase", 32'(phases()), 32'b00000);
    check("post_rst_op", 32'(op), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
